// File: rtl/led_bar_arbiter.sv
// led_bar_arbiter: shares the 8-LED one-hot bar between keypad and status requesters.
// Optional macro LED_BLINK_EN makes status-owned displays blink.
module led_bar_arbiter #(
    parameter int          HOLD_CYCLES  = 50_000_000,
    parameter int          GAP_CYCLES   = 5_000_000,
    parameter logic [3:0]  IDLE_CODE    = 4'hF,
    parameter int          BLINK_CYCLES = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       kp_req,
    input  logic [2:0] kp_code,
    output logic       kp_ack,
    input  logic       st_req,
    input  logic [2:0] st_code,
    output logic       st_ack,
    output logic [3:0] num,
    output logic       busy,
    output logic [1:0] owner
);

    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_C  = (MAX_HG > BLINK_CYCLES) ? MAX_HG : BLINK_CYCLES;
    localparam int CW     = $clog2(MAX_C) + 1;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_KP   = 2'b01;
    localparam logic [1:0] OWN_ST   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHOW,
        S_GAP
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last_kp;
    logic          r_kp_ack;
    logic          r_st_ack;
    logic [3:0]    r_num;
    logic          r_busy;
    logic [1:0]    r_owner;
    logic          w_grant_st;

`ifdef LED_BLINK_EN
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);
    logic [CW-1:0] r_blink_cnt;
    logic          r_blink_on;
    logic [2:0]    r_code;
`endif

    // Round-robin tie break: status wins a tie when keypad was granted last
    assign w_grant_st = st_req && (!kp_req || r_last_kp);

    // Main sequencer: arbitration, hold timing, blank gap and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_last_kp <= 1'b1;
            r_kp_ack  <= 1'b0;
            r_st_ack  <= 1'b0;
            r_num     <= IDLE_CODE;
            r_busy    <= 1'b0;
            r_owner   <= OWN_NONE;
`ifdef LED_BLINK_EN
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
            r_code      <= 3'd0;
`endif
        end else begin
            r_kp_ack <= 1'b0;
            r_st_ack <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (kp_req || st_req) begin
                        r_state <= S_SHOW;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
`ifdef LED_BLINK_EN
                        r_blink_cnt <= '0;
                        r_blink_on  <= 1'b1;
`endif
                        if (w_grant_st) begin
                            r_st_ack  <= 1'b1;
                            r_num     <= {1'b0, st_code};
                            r_owner   <= OWN_ST;
                            r_last_kp <= 1'b0;
`ifdef LED_BLINK_EN
                            r_code    <= st_code;
`endif
                        end else begin
                            r_kp_ack  <= 1'b1;
                            r_num     <= {1'b0, kp_code};
                            r_owner   <= OWN_KP;
                            r_last_kp <= 1'b1;
`ifdef LED_BLINK_EN
                            r_code    <= kp_code;
`endif
                        end
                    end
                end
                S_SHOW: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= S_GAP;
                        r_num   <= IDLE_CODE;
                        r_owner <= OWN_NONE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`ifdef LED_BLINK_EN
                        if (r_owner == OWN_ST) begin
                            if (r_blink_cnt == BLINK_LAST) begin
                                r_blink_cnt <= '0;
                                r_blink_on  <= !r_blink_on;
                                r_num       <= r_blink_on ? IDLE_CODE
                                                          : {1'b0, r_code};
                            end else begin
                                r_blink_cnt <= r_blink_cnt + 1'b1;
                            end
                        end
`endif
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_num   <= IDLE_CODE;
                    r_owner <= OWN_NONE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign kp_ack = r_kp_ack;
    assign st_ack = r_st_ack;
    assign num    = r_num;
    assign busy   = r_busy;
    assign owner  = r_owner;

endmodule
